// File: rtl/uart_rx_flow.sv
// uart_rx_flow: oversampled UART receiver feeding a first-word-fall-through
// receive FIFO, with registered RTS flow control derived from FIFO occupancy.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_flow #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_THRESH = 12,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            baud_divisor,
    input  logic                        uart_rx,
    output logic                        uart_rts_n,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_start,
    output logic                        byte_received,
    output logic                        rx_error,
    output logic                        rx_overrun
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                        parity_en,
    input  logic                        parity_odd,
    output logic                        rx_parity_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(RTS_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic                 r_sync1, r_sync2, r_sync_prev;
    logic [DIV_W-1:0]     r_div_cnt;
    state_t               r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_start, r_byte_received, r_rx_error, r_rx_overrun;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_valid;
    logic [DATA_BITS-1:0] r_head;
    logic                 r_rts_n;

    logic                 w_rx, w_fall, w_tick, w_restart;
    logic                 w_stop_sample, w_par_ok, w_good, w_full, w_push, w_pop;
    logic [CW-1:0]        w_cnt_next, w_cnt_after_pop;
    logic [AW-1:0]        w_rd_next;

`ifdef UART_RX_PARITY_EN
    logic                 r_par_chk, r_par_bit, r_parity_err;
    assign w_par_ok      = !r_par_chk || (r_par_bit == ((^r_shift) ^ parity_odd));
    assign rx_parity_err = r_parity_err;
`else
    assign w_par_ok      = 1'b1;
`endif

    assign w_rx            = r_sync2;
    assign w_fall          = r_sync_prev & ~r_sync2;
    assign w_tick          = (r_div_cnt == '0);
    assign w_restart       = (r_state == S_IDLE) && w_fall;
    assign w_stop_sample   = (r_state == S_STOP) && w_tick && (r_tick_cnt == FULL_M1);
    assign w_good          = w_stop_sample && w_rx && w_par_ok;
    // Full test uses the pre-pop occupancy, so a same-cycle pop never frees a slot.
    assign w_full          = (r_count == DEPTH_C);
    assign w_push          = w_good && !w_full;
    assign w_pop           = r_valid && rx_ready;
    assign w_cnt_next      = r_count + CW'(w_push) - CW'(w_pop);
    assign w_cnt_after_pop = r_count - CW'(w_pop);
    assign w_rd_next       = r_rd_ptr + AW'(w_pop);

    assign uart_rts_n    = r_rts_n;
    assign rx_data       = r_head;
    assign rx_valid      = r_valid;
    assign fifo_count    = r_count;
    assign frame_start   = r_frame_start;
    assign byte_received = r_byte_received;
    assign rx_error      = r_rx_error;
    assign rx_overrun    = r_rx_overrun;

    // Two-flop synchroniser plus previous-value flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= uart_rx;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // Oversample tick down-counter; restarted on a start edge so the phase aligns to the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_restart || w_tick) begin
            r_div_cnt <= baud_divisor;
        end else begin
            r_div_cnt <= r_div_cnt - DIV_W'(1);
        end
    end

    // Receive FSM: start validation, data shift, optional parity, stop check and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_tick_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_frame_start   <= 1'b0;
            r_byte_received <= 1'b0;
            r_rx_error      <= 1'b0;
            r_rx_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_chk       <= 1'b0;
            r_par_bit       <= 1'b0;
            r_parity_err    <= 1'b0;
`endif
        end else begin
            r_frame_start   <= 1'b0;
            r_byte_received <= w_push;
            r_rx_error      <= w_stop_sample && !w_rx;
            r_rx_overrun    <= w_good && w_full;
`ifdef UART_RX_PARITY_EN
            r_parity_err    <= w_stop_sample && !w_par_ok;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == HALF_M1) begin
                            r_tick_cnt <= '0;
                            if (w_rx) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state       <= S_DATA;
                                r_frame_start <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                r_par_chk     <= parity_en;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt  <= r_bit_cnt + BW'(1);
                            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= r_par_chk ? S_PARITY : S_STOP;
`else
                                r_state <= S_STOP;
`endif
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_par_bit  <= w_rx;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == FULL_M1) begin
                            r_tick_cnt <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy, registered FWFT head and RTS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
            r_rts_n  <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_cnt_next;
            r_valid  <= (w_cnt_next != '0);
            // Head comes from the incoming byte when it lands in an otherwise empty FIFO.
            if (w_cnt_next != '0) begin
                r_head <= (w_cnt_after_pop == '0) ? r_shift : r_mem[w_rd_next];
            end
            r_rts_n  <= (r_count >= THRESH_C);
        end
    end

endmodule
